// File: rtl/in_buffer_6.sv
// in_buffer_6 -- input-port flit FIFO for one router port.
//
// Receives flits from a neighbour's output buffer on a FLIT/VALID/stall
// handshake, holds up to DEPTH flits and presents the oldest one to the
// router core on a read/empty interface. A small framing tracker checks
// header/tail flags on every accepted flit. Flits that break framing are
// consumed but not stored, and they set a sticky error flag.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   FLIT_in        flit from upstream (bit 66 header, bit 65 tail)
//   VALID_in       upstream presents a flit this cycle
//   FWDAUX1_in     reserved, ignored
//   BWDAUX1_out    stall to upstream (1 = flit not accepted this cycle)
//   BWDAUX2_out    reserved, tied 0
//   BWDAUX3_out    reserved, tied 0
//   read           core pops the head flit
//   data_out       head flit
//   empty          no flits stored
//   head_is_header head flit carries the header flag
//   proto_err      sticky framing-error flag
module in_buffer_6 #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned FLIT_W = 67
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] FLIT_in,
  input  logic              VALID_in,
  input  logic              FWDAUX1_in,
  output logic              BWDAUX1_out,
  output logic              BWDAUX2_out,
  output logic              BWDAUX3_out,
  input  logic              read,
  output logic [FLIT_W-1:0] data_out,
  output logic              empty,
  output logic              head_is_header,
  output logic              proto_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              err_q, err_d;

  logic full;
  logic accept;
  logic store;
  logic pop;
  logic flit_hdr;
  logic flit_tail;
  logic unused_aux;

  assign unused_aux = FWDAUX1_in;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stall depends on registered occupancy only, so a same-cycle pop never
  // releases it and upstream sees a glitch-free signal.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign BWDAUX1_out = full;
  assign BWDAUX2_out = 1'b0;
  assign BWDAUX3_out = 1'b0;

  assign accept    = VALID_in && !full;
  assign flit_hdr  = FLIT_in[FLIT_W-1];
  assign flit_tail = FLIT_in[FLIT_W-2];

  assign empty          = (count_q == '0);
  assign data_out       = mem_q[rd_ptr_q];
  assign head_is_header = !empty && data_out[FLIT_W-1];
  assign proto_err      = err_q;

  assign pop = read && !empty;

  // Framing check: a packet opens with a header and closes with a tail.
  // Out-of-place flits are dropped (still consumed from upstream).
  always_comb begin
    store   = 1'b0;
    state_d = state_q;
    err_d   = err_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (flit_hdr) begin
            store = 1'b1;
            if (!flit_tail) state_d = ST_BODY;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          if (!flit_hdr) begin
            store = 1'b1;
            if (flit_tail) state_d = ST_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (store && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !store) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      err_q    <= err_d;
      if (store) mem_q[wr_ptr_q] <= FLIT_in;
    end
  end

endmodule
